// File: rtl/rr_packet_mux_arbiter_if.sv
// rr_packet_mux_arbiter_if: requester-side and consumer-side signals of the packet arbiter
interface rr_packet_mux_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] in_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0] in_last;
  logic [NUM_REQ-1:0] in_ready;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_last;
  logic out_ready;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic busy;
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant_onehot, grant_idx, busy
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_data, out_last, grant_onehot, grant_idx, busy
  );
endinterface

// File: rtl/rr_packet_mux_arbiter.sv
// rr_packet_mux_arbiter: round-robin arbiter that locks one of NUM_REQ sources onto a shared channel per packet
module rr_packet_mux_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic clk,
  input logic rst,
  rr_packet_mux_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state;
  logic [IDX_W-1:0] ptr, gidx, pick, ptr_nxt;
  logic locked, release_pkt;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // scan from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    logic [IDX_W-1:0] c;
    c = '0;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = IDX_W'((int'(ptr) + k) % NUM_REQ);
      pick = bus.in_valid[c] ? c : pick;
    end
  end
  assign locked = state == LOCKED;
  assign bus.busy = locked;
  assign bus.grant_idx = locked ? gidx : '0;
  assign bus.grant_onehot = locked ? (NUM_REQ'(1) << gidx) : '0;
  assign bus.out_valid = locked & bus.in_valid[gidx];
  assign bus.out_data = bus.out_valid ? words[gidx] : '0;
  assign bus.out_last = bus.out_valid & bus.in_last[gidx];
  assign bus.in_ready = bus.grant_onehot & {NUM_REQ{bus.out_ready}};
  assign release_pkt = bus.out_valid & bus.out_ready & bus.out_last;
  assign ptr_nxt = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
    end else if (!locked && |bus.in_valid) begin
      state <= LOCKED;
      gidx <= pick;
    end else if (release_pkt) begin
      state <= IDLE;
      ptr <= ptr_nxt;
    end
endmodule

// File: tb/tb_rr_packet_mux_arbiter.sv
// tb_rr_packet_mux_arbiter: scoreboard bench for the round-robin packet arbiter (4- and 3-requester instances)
module tb_rr_packet_mux_arbiter;
  typedef struct packed {
    logic [1:0] idx;
    logic last;
    logic [7:0] data;
    logic [31:0] cyc;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cyc = '0;
  int total = 0;
  int bad = 0;
  ent_t exp_q [$];
  ent_t obs [$];
  ent_t e, o;
  logic [8:0] pq [4][$];
  logic [3:0] hold = '0;
  logic [3:0] acc;
  bit ok;
  rr_packet_mux_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) b4 ();
  rr_packet_mux_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) b3 ();
  rr_packet_mux_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  rr_packet_mux_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: record every word the 4-way channel accepts
  always @(negedge clk)
    if (!rst && b4.out_valid && b4.out_ready)
      obs.push_back(ent_t'{b4.grant_idx, b4.out_last, b4.out_data, cyc});
  // per-requester producers: present the head word, pop it once accepted
  initial begin
    logic [8:0] w;
    b4.in_valid = '0;
    b4.in_data = '0;
    b4.in_last = '0;
    forever begin
      @(negedge clk);
      acc = rst ? 4'b0 : (b4.in_valid & b4.in_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        w = 9'h0;
        if (pq[i].size() > 0) w = pq[i][0];
        b4.in_valid[i] = pq[i].size() > 0 && !hold[i];
        b4.in_last[i] = w[8];
        b4.in_data[i*8 +: 8] = w[7:0];
      end
    end
  end
  task automatic at_p;
    @(posedge clk);
    #2;
  endtask
  task automatic pkt(input int r, input int n, input logic [7:0] base, input bit chk);
    for (int k = 0; k < n; k++) begin
      pq[r].push_back({k == n - 1, base + 8'(k)});
      if (chk) exp_q.push_back(ent_t'{2'(r), k == n - 1, base + 8'(k), 32'd0});
    end
  endtask
  task automatic wait_obs(input int n, input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = obs.size() >= n;
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset;
    #1;
    total++;
    if (b4.busy !== 1'b0 || b4.out_valid !== 1'b0 || b4.out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got busy=%b valid=%b last=%b want 0/0/0", b4.busy, b4.out_valid, b4.out_last);
    end
    total++;
    if (b4.grant_onehot !== 4'b0 || b4.grant_idx !== 2'd0 || b4.in_ready !== 4'b0 || b4.out_data !== 8'h0) begin
      bad++;
      $display("FAIL reset_bus got onehot=%b idx=%0d ready=%b data=%h want zeros", b4.grant_onehot, b4.grant_idx, b4.in_ready, b4.out_data);
    end
    total++;
    if (b3.busy !== 1'b0 || b3.grant_onehot !== 3'b0 || b3.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut3 got busy=%b onehot=%b valid=%b want zeros", b3.busy, b3.grant_onehot, b3.out_valid);
    end
    at_p();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (b4.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b want 0", b4.busy);
    end
  endtask
  task automatic test_single;
    at_p();
    b4.out_ready = 1'b1;
    pkt(2, 3, 8'hA1, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (b4.busy !== 1'b0 || b4.in_ready !== 4'b0) begin
      bad++;
      $display("FAIL single_latency got busy=%b ready=%b want 0/0000", b4.busy, b4.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (b4.grant_idx !== 2'd2 || b4.out_data !== 8'hA1 + 8'(k) || b4.out_last !== (k == 2)) begin
        bad++;
        $display("FAIL single_word%0d got idx=%0d data=%h last=%b want 2/%h/%b", k, b4.grant_idx, b4.out_data, b4.out_last, 8'hA1 + 8'(k), k == 2);
      end
    end
    @(negedge clk);
    total++;
    if (b4.busy !== 1'b0 || b4.grant_onehot !== 4'b0) begin
      bad++;
      $display("FAIL single_release got busy=%b onehot=%b want 0/0000", b4.busy, b4.grant_onehot);
    end
    wait_obs(exp_q.size(), 40, ok);
    total++;
    if (!ok || obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL single_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      total++;
      if ({o.idx, o.last, o.data} !== {e.idx, e.last, e.data}) begin
        bad++;
        $display("FAIL single_sb got=%0d/%b/%h want=%0d/%b/%h", o.idx, o.last, o.data, e.idx, e.last, e.data);
      end
    end
    exp_q.delete();
    obs.delete();
  endtask
  task automatic test_round_robin;
    int pc;
    logic pl;
    pc = 0;
    pl = 1'b0;
    at_p();
    pkt(3, 2, 8'h30, 1'b1);
    pkt(0, 2, 8'h00, 1'b1);
    pkt(1, 2, 8'h10, 1'b1);
    pkt(2, 2, 8'h20, 1'b1);
    pkt(3, 2, 8'h38, 1'b1);
    wait_obs(exp_q.size(), 80, ok);
    total++;
    if (!ok || obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rr_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      total++;
      if ({o.idx, o.last, o.data} !== {e.idx, e.last, e.data}) begin
        bad++;
        $display("FAIL rr_sb got=%0d/%b/%h want=%0d/%b/%h", o.idx, o.last, o.data, e.idx, e.last, e.data);
      end
      if (i > 0) begin
        total++;
        if (int'(o.cyc) - pc != (pl ? 2 : 1)) begin
          bad++;
          $display("FAIL rr_gap got=%0d want=%0d", int'(o.cyc) - pc, pl ? 2 : 1);
        end
      end
      pc = int'(o.cyc);
      pl = o.last;
    end
    exp_q.delete();
    obs.delete();
  endtask
  task automatic test_backpressure;
    at_p();
    pkt(0, 4, 8'h50, 1'b1);
    repeat (3) at_p();
    b4.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (b4.out_data !== 8'h51 || b4.out_valid !== 1'b1 || b4.in_ready !== 4'b0 || b4.busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d got data=%h valid=%b ready=%b busy=%b want 51/1/0000/1", k, b4.out_data, b4.out_valid, b4.in_ready, b4.busy);
      end
    end
    at_p();
    b4.out_ready = 1'b1;
    wait_obs(exp_q.size(), 40, ok);
    total++;
    if (!ok || obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      total++;
      if ({o.idx, o.last, o.data} !== {e.idx, e.last, e.data}) begin
        bad++;
        $display("FAIL bp_sb got=%0d/%b/%h want=%0d/%b/%h", o.idx, o.last, o.data, e.idx, e.last, e.data);
      end
    end
    exp_q.delete();
    obs.delete();
  endtask
  task automatic test_owner_bubble;
    at_p();
    pkt(1, 4, 8'h60, 1'b1);
    pkt(0, 2, 8'h70, 1'b1);
    repeat (3) at_p();
    hold = 4'b0010;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        at_p();
        hold = 4'b0000;
      end
      @(negedge clk);
      total++;
      if (b4.out_valid !== 1'b0 || b4.grant_idx !== 2'd1 || b4.busy !== 1'b1 || b4.in_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL bubble%0d got valid=%b idx=%0d busy=%b ready0=%b want 0/1/1/0", k, b4.out_valid, b4.grant_idx, b4.busy, b4.in_ready[0]);
      end
    end
    wait_obs(exp_q.size(), 40, ok);
    total++;
    if (!ok || obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bubble_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      total++;
      if ({o.idx, o.last, o.data} !== {e.idx, e.last, e.data}) begin
        bad++;
        $display("FAIL bubble_sb got=%0d/%b/%h want=%0d/%b/%h", o.idx, o.last, o.data, e.idx, e.last, e.data);
      end
    end
    exp_q.delete();
    obs.delete();
  endtask
  task automatic test_async_reset;
    at_p();
    pkt(3, 4, 8'h80, 1'b0);
    exp_q.push_back(ent_t'{2'd3, 1'b0, 8'h80, 32'd0});
    repeat (3) at_p();
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (b4.out_valid !== 1'b0 || b4.busy !== 1'b0 || b4.grant_onehot !== 4'b0 || b4.in_ready !== 4'b0 || b4.out_data !== 8'h0) begin
      bad++;
      $display("FAIL areset_now got valid=%b busy=%b onehot=%b ready=%b data=%h want zeros", b4.out_valid, b4.busy, b4.grant_onehot, b4.in_ready, b4.out_data);
    end
    pq[3].delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    at_p();
    pkt(0, 1, 8'h90, 1'b1);
    pkt(3, 1, 8'h91, 1'b1);
    wait_obs(exp_q.size(), 40, ok);
    total++;
    if (!ok || obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL areset_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front();
      o = obs.pop_front();
      total++;
      if ({o.idx, o.last, o.data} !== {e.idx, e.last, e.data}) begin
        bad++;
        $display("FAIL areset_sb got=%0d/%b/%h want=%0d/%b/%h", o.idx, o.last, o.data, e.idx, e.last, e.data);
      end
    end
    exp_q.delete();
    obs.delete();
  endtask
  task automatic test_three_way;
    at_p();
    b3.out_ready = 1'b1;
    b3.in_last = 3'b111;
    b3.in_data = {8'h22, 8'h11, 8'h33};
    b3.in_valid = 3'b010;
    repeat (2) @(negedge clk);
    total++;
    if (b3.grant_idx !== 2'd1 || b3.out_data !== 8'h11) begin
      bad++;
      $display("FAIL nr3_first got idx=%0d data=%h want 1/11", b3.grant_idx, b3.out_data);
    end
    at_p();
    b3.in_valid = 3'b101;
    @(negedge clk);
    total++;
    if (b3.busy !== 1'b0) begin
      bad++;
      $display("FAIL nr3_bubble1 got busy=%b want 0", b3.busy);
    end
    @(negedge clk);
    total++;
    if (b3.grant_idx !== 2'd2 || b3.grant_onehot !== 3'b100 || b3.out_data !== 8'h22 || b3.in_ready !== 3'b100) begin
      bad++;
      $display("FAIL nr3_ptr2 got idx=%0d onehot=%b data=%h ready=%b want 2/100/22/100", b3.grant_idx, b3.grant_onehot, b3.out_data, b3.in_ready);
    end
    at_p();
    b3.in_data = {8'h22, 8'h44, 8'h33};
    b3.in_valid = 3'b011;
    @(negedge clk);
    total++;
    if (b3.busy !== 1'b0) begin
      bad++;
      $display("FAIL nr3_bubble2 got busy=%b want 0", b3.busy);
    end
    @(negedge clk);
    total++;
    if (b3.grant_idx !== 2'd0 || b3.out_data !== 8'h33) begin
      bad++;
      $display("FAIL nr3_wrap got idx=%0d data=%h want 0/33", b3.grant_idx, b3.out_data);
    end
    at_p();
    b3.in_valid = 3'b010;
    repeat (2) @(negedge clk);
    total++;
    if (b3.grant_idx !== 2'd1 || b3.out_data !== 8'h44) begin
      bad++;
      $display("FAIL nr3_next got idx=%0d data=%h want 1/44", b3.grant_idx, b3.out_data);
    end
    at_p();
    b3.in_valid = 3'b000;
    repeat (2) @(negedge clk);
    total++;
    if (b3.busy !== 1'b0) begin
      bad++;
      $display("FAIL nr3_end got busy=%b want 0", b3.busy);
    end
  endtask
  initial begin
    b3.in_valid = '0;
    b3.in_data = '0;
    b3.in_last = '0;
    b3.out_ready = 1'b0;
    b4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_owner_bubble();
    test_async_reset();
    test_three_way();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
